id_ex_operand_stage: RTL

- ID/EX pipeline register for the 5-stage pipelined processor.
- Captures decoded operands and control from ID, then presents them to EX.
- Generates registered 2-bit select codes for the EX-stage 4:1 operand muxes (ALU A, ALU B, store data).
- Detects load-use hazards and inserts bubbles; honours flush and hold.

---
 rtl/id_ex_operand_stage_if.sv | 80 ++++++++
 rtl/id_ex_operand_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
//   Bundle of the ID-side inputs and EX-side outputs of the ID/EX operand
//   stage. Only clk and rst_n stay outside the bundle.
//
//   ID side   : id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
//               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
//               id_reg_write, id_mem_read, id_mem_write,
//               id_alu_src_a, id_alu_src_b, id_alu_op
//   MEM side  : exmem_rd, exmem_reg_write
//   Pipeline  : flush, hold, load_use_stall
//   EX side   : ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc,
//               ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_alu_op,
//               ex_sel_a, ex_sel_b, ex_sel_st
//
//   master : the surrounding pipeline (drives ID/MEM/control, reads EX)
//   slave  : the ID/EX stage itself
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5,
  parameter int OPW  = 4
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RIDX-1:0] id_rs1;
  logic [RIDX-1:0] id_rs2;
  logic [RIDX-1:0] id_rd;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_alu_src_a;
  logic            id_alu_src_b;
  logic [OPW-1:0]  id_alu_op;
  logic [RIDX-1:0] exmem_rd;
  logic            exmem_reg_write;
  logic            flush;
  logic            hold;
  logic            load_use_stall;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RIDX-1:0] ex_rd;
  logic [OPW-1:0]  ex_alu_op;
  logic [1:0]      ex_sel_a;
  logic [1:0]      ex_sel_b;
  logic [1:0]      ex_sel_st;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_mem_write,
           id_alu_src_a, id_alu_src_b, id_alu_op,
           exmem_rd, exmem_reg_write, flush, hold,
    input  load_use_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_alu_op,
           ex_sel_a, ex_sel_b, ex_sel_st
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_mem_write,
           id_alu_src_a, id_alu_src_b, id_alu_op,
           exmem_rd, exmem_reg_write, flush, hold,
    output load_use_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_alu_op,
           ex_sel_a, ex_sel_b, ex_sel_st
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register of the 5-stage core. Captures the decoded
//   instruction from ID, presents it to EX one cycle later, and produces the
//   registered 2-bit select codes for the EX-stage operand muxes:
//     00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback value,
//     11 PC (sel_a) / immediate (sel_b). ex_sel_st never carries 11.
//   Detects RAW hazards that forwarding cannot cover and inserts bubbles.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every registered output
//   bus    : id_ex_operand_stage_if.slave (ID inputs, MEM producer info,
//            flush/hold, load_use_stall, all EX-side outputs)
//
// Build option
//   ID_EX_FWD_EN defined   : forwarding selects 01/10 are generated; only a
//                            load in EX feeding the ID instruction stalls.
//   ID_EX_FWD_EN undefined : selects are only 00/11; any RAW match against
//                            the EX or MEM instruction stalls until it clears.
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5,
  parameter int OPW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_operand_stage_if.slave  bus
);

  // EX-resident instruction
  logic            r_ex_valid;
  logic            r_ex_reg_write;
  logic            r_ex_mem_read;
  logic            r_ex_mem_write;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_rs1_data;
  logic [XLEN-1:0] r_ex_rs2_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [RIDX-1:0] r_ex_rd;
  logic [OPW-1:0]  r_ex_alu_op;
  logic [1:0]      r_ex_sel_a;
  logic [1:0]      r_ex_sel_b;
  logic [1:0]      r_ex_sel_st;

  // Source operand view: index 0 is rs1, index 1 is rs2
  logic [RIDX-1:0] w_rs_idx [2];
  logic [1:0]      w_rs_use;
  logic [1:0]      w_ex_hit;
  logic [1:0]      w_mem_hit;
  logic [1:0]      w_fwd [2];

  logic            w_ex_wr;
  logic            w_mem_wr;
  logic            w_hazard;
  logic            w_stall;
  logic            w_bubble;
  logic            w_load;
  logic [1:0]      w_sel_a_next;
  logic [1:0]      w_sel_b_next;

  assign w_rs_idx[0] = bus.id_rs1;
  assign w_rs_idx[1] = bus.id_rs2;
  assign w_rs_use    = {bus.id_use_rs2, bus.id_use_rs1};

  // A producer only counts if it really writes a non-zero register; a match
  // on x0 is therefore impossible because the indices would have to be equal.
  assign w_ex_wr  = r_ex_valid & r_ex_reg_write & (r_ex_rd != '0);
  assign w_mem_wr = bus.exmem_reg_write & (bus.exmem_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_ex_hit[gi]  = w_rs_use[gi] & w_ex_wr  & (w_rs_idx[gi] == r_ex_rd);
      assign w_mem_hit[gi] = w_rs_use[gi] & w_mem_wr & (w_rs_idx[gi] == bus.exmem_rd);
`ifdef ID_EX_FWD_EN
      // The EX producer will be in MEM next cycle (01); the MEM producer will
      // be in WB (10). The younger producer wins.
      assign w_fwd[gi] = w_ex_hit[gi]  ? 2'b01 :
                         w_mem_hit[gi] ? 2'b10 : 2'b00;
`else
      assign w_fwd[gi] = 2'b00;
`endif
    end
  endgenerate

`ifdef ID_EX_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = r_ex_mem_read & (|w_ex_hit);
`else
  assign w_hazard = (|w_ex_hit) | (|w_mem_hit);
`endif

  // A held or flushed cycle never reports a stall; the bubble is driven by
  // flush itself, and hold freezes everything anyway.
  assign w_stall = bus.id_valid & w_hazard & ~bus.hold & ~bus.flush;

  assign w_bubble = bus.flush | w_stall;
  assign w_load   = ~bus.flush & ~bus.hold & ~w_stall;

  // Store data always carries the rs2 forwarding code, even when the ALU B
  // input is overridden by the immediate.
  assign w_sel_a_next = bus.id_alu_src_a ? 2'b11 : w_fwd[0];
  assign w_sel_b_next = bus.id_alu_src_b ? 2'b11 : w_fwd[1];

  // Control and selects: bubble, freeze, or capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_sel_a     <= 2'b00;
      r_ex_sel_b     <= 2'b00;
      r_ex_sel_st    <= 2'b00;
    end else if (w_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_sel_a     <= 2'b00;
      r_ex_sel_b     <= 2'b00;
      r_ex_sel_st    <= 2'b00;
    end else if (w_load) begin
      r_ex_valid     <= bus.id_valid;
      r_ex_reg_write <= bus.id_reg_write & bus.id_valid;
      r_ex_mem_read  <= bus.id_mem_read  & bus.id_valid;
      r_ex_mem_write <= bus.id_mem_write & bus.id_valid;
      r_ex_sel_a     <= w_sel_a_next;
      r_ex_sel_b     <= w_sel_b_next;
      r_ex_sel_st    <= w_fwd[1];
    end
  end

  // Data fields keep their last value through bubbles and holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_rd       <= '0;
      r_ex_alu_op   <= '0;
    end else if (w_load) begin
      r_ex_pc       <= bus.id_pc;
      r_ex_rs1_data <= bus.id_rs1_data;
      r_ex_rs2_data <= bus.id_rs2_data;
      r_ex_imm      <= bus.id_imm;
      r_ex_rd       <= bus.id_rd;
      r_ex_alu_op   <= bus.id_alu_op;
    end
  end

  assign bus.load_use_stall = w_stall;
  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_reg_write   = r_ex_reg_write;
  assign bus.ex_mem_read    = r_ex_mem_read;
  assign bus.ex_mem_write   = r_ex_mem_write;
  assign bus.ex_pc          = r_ex_pc;
  assign bus.ex_rs1_data    = r_ex_rs1_data;
  assign bus.ex_rs2_data    = r_ex_rs2_data;
  assign bus.ex_imm         = r_ex_imm;
  assign bus.ex_rd          = r_ex_rd;
  assign bus.ex_alu_op      = r_ex_alu_op;
  assign bus.ex_sel_a       = r_ex_sel_a;
  assign bus.ex_sel_b       = r_ex_sel_b;
  assign bus.ex_sel_st      = r_ex_sel_st;

endmodule
